lsu_mem_ctrl: RTL and testbench
===============================

# lsu_mem_ctrl

Load/store unit that sits between the RV32 execute stage and the word-addressed data memory. It accepts one byte, halfword or word load/store request at a time and converts it into word reads and writes on the memory port. The memory port has an asynchronous read and a synchronous write, and has no byte enables, so sub-word stores are read-modify-write. Load results are sign- or zero-extended and returned through a one-cycle response.

## Interface
- DATA_W, 32, data/word width (fixed 32; byte lanes = 4)
- ADDR_W, 32, byte-address width and memory word-index width
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 width/sign code
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_W  extended load data; 0 for stores and errors
- resp_err  out  1  illegal funct3, or misaligned access when splitting is disabled
- mem_WE  out  1  memory write enable
- mem_A  out  ADDR_W  word index = byte address >> 2, zero-extended
- mem_WD  out  DATA_W  memory write data
- mem_RD  in  DATA_W  memory read data, valid in the same cycle as mem_A

## Operation
- Handshake: a request is accepted on a rising edge with req_valid && req_ready. The unit captures req_* and ignores them afterwards.
- funct3 for loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. All other codes are illegal.
- funct3 for stores: 000 SB, 001 SH, 010 SW. All other codes are illegal.
- Little-endian byte lanes. off = addr[1:0]; size = 1, 2 or 4.
- Access kinds:
  - Aligned: off % size == 0.
  - Spanning: off + size > 4.
  - Word 0 is addr >> 2; word 1 is word 0 + 1, wrapping modulo 2^ADDR_W.
- FSM states: IDLE, RD0, RD1, WR0, WR1, RESP.
- IDLE →
  - RESP with resp_err on illegal funct3, or on a misaligned access when splitting is disabled.
  - WR0 for an aligned SW.
  - RD0 for everything else.
- RD0: mem_A = word 0; latch mem_RD into buf0. Next state: RD1 if spanning, else WR0 for a store, else RESP.
- RD1: mem_A = word 1; latch buf1. Next state: WR0 for a store, else RESP.
- WR0: mem_WE = 1, mem_A = word 0, mem_WD = buf0 with the store bytes merged in. Next state: WR1 if spanning, else RESP.
- WR1: same as WR0 for word 1, carrying the high store bytes. Next state: RESP.
- RESP: resp_valid = 1 for exactly one cycle, then IDLE. resp_rdata is extracted from {buf1, buf0} >> (8*off), then sign-extended (LB, LH) or zero-extended (LBU, LHU).
- Outside WR0/WR1: mem_WE = 0 and mem_WD = 0. mem_A = 0 in IDLE and RESP.
- mem_WE = (state ∈ {WR0, WR1}) && !rst, so a reset edge never writes memory.
- Reset values: state IDLE; buf0/buf1 = 0; resp_valid, resp_err and resp_rdata = 0; req_ready = 0 while rst is high.
- Reset mid-operation aborts the access with no response. For a spanning store reset after WR0, word 0 keeps its new value.

## Timing
T is the accept edge; the number given is the cycle in which resp_valid is high.
- Error: T+1.
- Aligned SW: T+2 (mem_WE high in T+1).
- Aligned load: T+2.
- Sub-word store: T+3 (mem_WE high in T+2).
- Spanning load: T+3.
- Spanning store: T+5.
- Throughput: next accept no earlier than the cycle after RESP; req_ready is low throughout the access.

## Configuration
- LSU_MISALIGN_EN defined: misaligned accesses are split across two words as described above.
- LSU_MISALIGN_EN undefined: any access with off % size != 0 takes the error path. RD1 and WR1 are not synthesised, and memory is never touched.

## Structure
- Package lsu_pkg holds:
  - funct3 constants.
  - FSM state encoding.
  - The size/offset helper constants.
- Sub-module lsu_align (combinational) holds the byte-lane extract/extend for loads and the merge for stores. The FSM stays in lsu_mem_ctrl.

## Test plan
Preload mem[1] = 0x88776655 and mem[2] = 0x44332211.
- LB at 0x7 → resp_rdata 0xFFFFFF88 at T+2; LBU at 0x7 → 0x00000088.
- LHU at 0x6 → 0x00008877 at T+2.
- SB at 0x5 with wdata 0x000000AB → read of mem_A 1 in T+1, write of 0x8877AB55 to mem_A 1 in T+2, resp at T+3.
- SW at 0x8 with 0xDEADBEEF → no read cycle; mem_WE high in T+1 with mem_A 2; resp at T+2.
- LW at 0x6:
  - With LSU_MISALIGN_EN: 0x22118877 at T+3.
  - Without it: resp_err = 1 and rdata = 0 at T+1, with no memory access.
- SH at 0x7 with LSU_MISALIGN_EN, rst asserted during WR1 → mem[1] = 0xCD776655 for wdata 0xABCD, mem[2] unchanged, no resp_valid, req_ready high one cycle after rst drops.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM state
// encoding and the size/offset helpers used for lane alignment.
// Build option: LSU_MISALIGN_EN enables splitting of misaligned accesses.
package lsu_pkg;

    localparam int unsigned LANES = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        RD1,
        WR0,
        WR1,
        RESP
    } state_t;

    // Access size in bytes (1, 2 or 4) from the width bits of funct3.
    function automatic logic [2:0] access_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   access_size = 3'd1;
            2'b01:   access_size = 3'd2;
            default: access_size = 3'd4;
        endcase
    endfunction

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we)
            f3_legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        else
            f3_legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                       (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] off);
        logic [2:0] sz_m1;
        sz_m1 = access_size(f3) - 3'd1;
        is_aligned = ((off & sz_m1[1:0]) == 2'b00);
    endfunction

    function automatic logic is_spanning(input logic [2:0] f3, input logic [1:0] off);
        is_spanning = (({1'b0, off} + access_size(f3)) > 3'(LANES));
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Request/response and memory-port bundle for lsu_mem_ctrl.
// slave: the LSU itself; master: the execute stage plus memory side.
interface lsu_mem_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic              mem_WE;
    logic [ADDR_W-1:0] mem_A;
    logic [DATA_W-1:0] mem_WD;
    logic [DATA_W-1:0] mem_RD;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_RD,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_WE, mem_A, mem_WD
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_RD,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_WE, mem_A, mem_WD
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: load extract/extend from a two-word
// window, and store merge of right-aligned data into a two-word window.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [63:0] rd_pair,
    input  logic [63:0] old_pair,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [63:0] merged
);
    logic [31:0] shifted;
    logic [63:0] mask;
    logic [63:0] data;

    // Extract the addressed bytes and apply sign/zero extension.
    always_comb begin
        shifted = 32'(rd_pair >> {off, 3'b000});
        case (funct3)
            F3_B:    rdata = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    rdata = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    rdata = shifted;
            F3_BU:   rdata = {24'h0, shifted[7:0]};
            F3_HU:   rdata = {16'h0, shifted[15:0]};
            default: rdata = '0;
        endcase
    end

    // Overlay the store bytes onto the previously read words.
    always_comb begin
        case (funct3[1:0])
            2'b00:   mask = 64'h0000_0000_0000_00FF;
            2'b01:   mask = 64'h0000_0000_0000_FFFF;
            default: mask = 64'h0000_0000_FFFF_FFFF;
        endcase
        mask   = mask << {off, 3'b000};
        data   = {32'h0, wdata} << {off, 3'b000};
        merged = (old_pair & ~mask) | (data & mask);
    end
endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: converts byte/half/word requests into word reads and
// writes (read-modify-write for sub-word stores) on an async-read memory.
// Build option: LSU_MISALIGN_EN splits misaligned accesses over two words;
// without it, misaligned accesses return an error and touch no memory.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input logic          clk,
    input logic          rst,
    lsu_mem_ctrl_if.slave bus
);
    state_t            state;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic [ADDR_W-1:0] word0_q;
    logic [ADDR_W-1:0] word1;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] buf0;
    logic [DATA_W-1:0] buf1;
    logic [DATA_W-1:0] lo_sel;
    logic [DATA_W-1:0] hi_sel;
    logic [DATA_W-1:0] load_rdata;
    logic [63:0]       merged;
    logic              resp_valid_q;
    logic              resp_err_q;
    logic [DATA_W-1:0] resp_rdata_q;

    assign word1 = ADDR_W'(word0_q + 1'b1);

    // Load data is registered on the edge that latches the final read, so
    // the live memory word replaces the buffer it is about to land in.
    assign lo_sel = (state == RD0) ? bus.mem_RD : buf0;
    assign hi_sel = (state == RD1) ? bus.mem_RD : buf1;

    lsu_align u_align (
        .funct3   (f3_q),
        .off      (off_q),
        .rd_pair  ({hi_sel, lo_sel}),
        .old_pair ({buf1, buf0}),
        .wdata    (wdata_q),
        .rdata    (load_rdata),
        .merged   (merged)
    );

    // Access sequencer with registered response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            we_q         <= 1'b0;
            f3_q         <= '0;
            off_q        <= '0;
            word0_q      <= '0;
            wdata_q      <= '0;
            buf0         <= '0;
            buf1         <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q         <= bus.req_we;
                        f3_q         <= bus.req_funct3;
                        off_q        <= bus.req_addr[1:0];
                        word0_q      <= {2'b00, bus.req_addr[ADDR_W-1:2]};
                        wdata_q      <= bus.req_wdata;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= '0;
                        if (!f3_legal(bus.req_we, bus.req_funct3)) begin
                            resp_err_q   <= 1'b1;
                            resp_valid_q <= 1'b1;
                            state        <= RESP;
                        end else if (!is_aligned(bus.req_funct3, bus.req_addr[1:0])) begin
`ifdef LSU_MISALIGN_EN
                            state <= RD0;
`else
                            resp_err_q   <= 1'b1;
                            resp_valid_q <= 1'b1;
                            state        <= RESP;
`endif
                        end else if (bus.req_we && bus.req_funct3 == F3_W) begin
                            state <= WR0;
                        end else begin
                            state <= RD0;
                        end
                    end
                end
                RD0: begin
                    buf0 <= bus.mem_RD;
`ifdef LSU_MISALIGN_EN
                    if (is_spanning(f3_q, off_q)) begin
                        state <= RD1;
                    end else
`endif
                    if (we_q) begin
                        state <= WR0;
                    end else begin
                        resp_rdata_q <= load_rdata;
                        resp_valid_q <= 1'b1;
                        state        <= RESP;
                    end
                end
`ifdef LSU_MISALIGN_EN
                RD1: begin
                    buf1 <= bus.mem_RD;
                    if (we_q) begin
                        state <= WR0;
                    end else begin
                        resp_rdata_q <= load_rdata;
                        resp_valid_q <= 1'b1;
                        state        <= RESP;
                    end
                end
`endif
                WR0: begin
`ifdef LSU_MISALIGN_EN
                    if (is_spanning(f3_q, off_q)) begin
                        state <= WR1;
                    end else
`endif
                    begin
                        resp_valid_q <= 1'b1;
                        state        <= RESP;
                    end
                end
`ifdef LSU_MISALIGN_EN
                WR1: begin
                    resp_valid_q <= 1'b1;
                    state        <= RESP;
                end
`endif
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Memory port decode; the write strobe is gated by reset so an
    // aborting edge never commits a write.
    always_comb begin
        bus.mem_WE = 1'b0;
        bus.mem_A  = '0;
        bus.mem_WD = '0;
        case (state)
            RD0: bus.mem_A = word0_q;
            RD1: bus.mem_A = word1;
            WR0: begin
                bus.mem_WE = !rst;
                bus.mem_A  = word0_q;
                bus.mem_WD = merged[31:0];
            end
            WR1: begin
                bus.mem_WE = !rst;
                bus.mem_A  = word1;
                bus.mem_WD = merged[63:32];
            end
            default: ;
        endcase
    end

    assign bus.req_ready  = (state == IDLE) && !rst;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: directed requests push expected
// responses (data, error flag, cycle); a monitor pops and compares.
// Covers both builds of LSU_MISALIGN_EN.
module tb_lsu_mem_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          at;
    } exp_t;
    exp_t exp_q[$];

    logic [31:0] mem [0:15];

    lsu_mem_ctrl_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    lsu_mem_ctrl #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bus.mem_RD = mem[bus.mem_A[3:0]];
    always @(posedge clk) if (bus.mem_WE) mem[bus.mem_A[3:0]] <= bus.mem_WD;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: every response must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.resp_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp_rdata", bus.resp_rdata, e.rdata);
                chk("resp_err", {31'd0, bus.resp_err}, {31'd0, e.err});
                chk("resp_cycle", cyc, e.at);
            end
        end
    end

    // Drive one request at a negedge; lat = 0 means no response is expected.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] er, input logic ee,
                         input int lat);
        int t;
        for (int i = 0; i < 20 && !bus.req_ready; i++) @(negedge clk);
        chk("ready_before_issue", {31'd0, bus.req_ready}, 32'd1);
        t = cyc;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        if (lat != 0) exp_q.push_back('{rdata: er, err: ee, at: t + lat});
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        bus.req_wdata = '0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            chk("resp_timeout", 32'd1, 32'd0);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic preload();
        mem[1] = 32'h8877_6655;
        mem[2] = 32'h4433_2211;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        preload();
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0;
        bus.req_addr = '0; bus.req_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_mem_we", {31'd0, bus.mem_WE}, 32'd0);
        chk("rst_mem_a", bus.mem_A, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Aligned loads.
        issue(1'b0, 3'b000, 32'h7, '0, 32'hFFFF_FF88, 1'b0, 2); wait_done();
        issue(1'b0, 3'b100, 32'h7, '0, 32'h0000_0088, 1'b0, 2); wait_done();
        issue(1'b0, 3'b101, 32'h6, '0, 32'h0000_8877, 1'b0, 2); wait_done();
        issue(1'b0, 3'b001, 32'h6, '0, 32'hFFFF_8877, 1'b0, 2); wait_done();
        issue(1'b0, 3'b010, 32'h4, '0, 32'h8877_6655, 1'b0, 2); wait_done();

        // SB: read in T+1, write in T+2.
        issue(1'b1, 3'b000, 32'h5, 32'h0000_00AB, 32'h0, 1'b0, 3);
        @(negedge clk);
        chk("sb_t1_we", {31'd0, bus.mem_WE}, 32'd0);
        chk("sb_t1_a", bus.mem_A, 32'd1);
        chk("sb_t1_ready", {31'd0, bus.req_ready}, 32'd0);
        @(negedge clk);
        chk("sb_t2_we", {31'd0, bus.mem_WE}, 32'd1);
        chk("sb_t2_a", bus.mem_A, 32'd1);
        chk("sb_t2_wd", bus.mem_WD, 32'h8877_AB55);
        wait_done();
        chk("sb_mem1", mem[1], 32'h8877_AB55);

        // Aligned SW: write straight away.
        issue(1'b1, 3'b010, 32'h8, 32'hDEAD_BEEF, 32'h0, 1'b0, 2);
        @(negedge clk);
        chk("sw_t1_we", {31'd0, bus.mem_WE}, 32'd1);
        chk("sw_t1_a", bus.mem_A, 32'd2);
        chk("sw_t1_wd", bus.mem_WD, 32'hDEAD_BEEF);
        wait_done();
        chk("sw_mem2", mem[2], 32'hDEAD_BEEF);
        preload();

        // Illegal funct3 codes.
        issue(1'b0, 3'b011, 32'h4, '0, 32'h0, 1'b1, 1); wait_done();
        issue(1'b1, 3'b100, 32'h4, 32'h1234_5678, 32'h0, 1'b1, 1); wait_done();
        chk("illegal_mem1", mem[1], 32'h8877_6655);

`ifdef LSU_MISALIGN_EN
        issue(1'b0, 3'b010, 32'h6, '0, 32'h2211_8877, 1'b0, 3);
        @(negedge clk);
        chk("lw6_t1_a", bus.mem_A, 32'd1);
        @(negedge clk);
        chk("lw6_t2_a", bus.mem_A, 32'd2);
        wait_done();

        issue(1'b1, 3'b010, 32'h6, 32'hCAFE_F00D, 32'h0, 1'b0, 5); wait_done();
        chk("sw6_mem1", mem[1], 32'hF00D_6655);
        chk("sw6_mem2", mem[2], 32'h4433_CAFE);
        preload();

        // SH spanning words 1/2, reset lands during WR1.
        issue(1'b1, 3'b001, 32'h7, 32'h0000_ABCD, 32'h0, 1'b0, 0);
        @(negedge clk); chk("sh_rd0_a", bus.mem_A, 32'd1);
        @(negedge clk); chk("sh_rd1_a", bus.mem_A, 32'd2);
        @(negedge clk);
        chk("sh_wr0_we", {31'd0, bus.mem_WE}, 32'd1);
        chk("sh_wr0_wd", bus.mem_WD, 32'hCD77_6655);
        @(negedge clk);
        chk("sh_wr1_a", bus.mem_A, 32'd2);
        chk("sh_wr1_wd", bus.mem_WD, 32'h4433_22AB);
        rst = 1'b1;
        #1 chk("sh_rst_we", {31'd0, bus.mem_WE}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("sh_ready_after_rst", {31'd0, bus.req_ready}, 32'd1);
        chk("sh_mem1", mem[1], 32'hCD77_6655);
        chk("sh_mem2", mem[2], 32'h4433_2211);
        repeat (3) @(negedge clk);
`else
        issue(1'b0, 3'b010, 32'h6, '0, 32'h0, 1'b1, 1);
        @(negedge clk);
        chk("lw6_err_we", {31'd0, bus.mem_WE}, 32'd0);
        chk("lw6_err_a", bus.mem_A, 32'd0);
        wait_done();
        issue(1'b1, 3'b001, 32'h7, 32'h0000_ABCD, 32'h0, 1'b1, 1); wait_done();
        chk("sh7_err_mem1", mem[1], 32'h8877_6655);
        chk("sh7_err_mem2", mem[2], 32'h4433_2211);
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
